compute_scheduler: RTL

Sequencer and arbiter for the shared single-precision FP unit behind `computation_master`. Accepts 128-bit job words from two requesters: the local UART receive path (`rx_data`/`rx_irq`) and the peer link. Grants one job at a time round-robin and issues its two operand pairs to the FP unit in sequence. Packs both results into a 128-bit transmit word and keeps sticky overflow/underflow status.

---
 rtl/compute_sched_pkg.sv | 40 ++++
 rtl/sched_rr_arbiter.sv | 44 ++++
 rtl/compute_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/compute_sched_pkg.sv
// ---------------------------------------------------------------------------
// compute_sched_pkg
// Shared types and constants for compute_scheduler and its arbiter:
//   - sched_state_e : job sequencing FSM states
//   - JOB_*_LSB     : operand field offsets inside a 128-bit job word
//   - TX_SRC_BIT    : position of the source bit in the transmit word
//   - QNAN          : result substituted when the FP unit never answers
//   - slot_t        : one holding slot (valid flag + job word)
// ---------------------------------------------------------------------------
package compute_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_EMIT
  } sched_state_e;

  localparam int JOB_A1_LSB = 96;
  localparam int JOB_A0_LSB = 64;
  localparam int JOB_B1_LSB = 32;
  localparam int JOB_B0_LSB = 0;

  localparam int TX_SRC_BIT = 64;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
  } slot_t;

  // Extract one 32-bit operand from a job word.
  function automatic logic [31:0] job_field(input logic [127:0] word, input int lsb);
    return word[lsb +: 32];
  endfunction

endpackage

// File: rtl/sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sched_rr_arbiter
// Two-request round-robin arbiter with a registered priority pointer.
// Ports:
//   clock   in  : rising-edge clock
//   reset   in  : asynchronous active-high reset (pointer back to local)
//   req     in 2: request vector, bit 0 = local, bit 1 = peer
//   advance in  : a grant is being taken this cycle; rotate the pointer
//   grant   out2: one-hot grant (combinational from req and pointer)
// ---------------------------------------------------------------------------
module sched_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 0: local wins a tie, 1: peer wins a tie.
  logic r_ptr;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = r_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      // Point at whichever requester was not just served.
      r_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/compute_scheduler.sv
// ---------------------------------------------------------------------------
// compute_scheduler
// Arbitrates 128-bit FP jobs from the local receive path and the peer link,
// issues each job's two operand pairs to a shared FP unit and packs both
// results into one transmit word. Keeps sticky overflow/underflow status.
//
// Build option: define SCHED_TIMEOUT_EN to bound every FP wait by
// TIMEOUT_CYCLES; an unanswered operation then yields qNaN and sets the
// sticky `timeout` output (the port exists only in that build).
//
// Ports:
//   clock, reset            : clock, async active-high reset
//   rx_data/rx_irq          : local job word + one-cycle valid
//   peer_data/peer_valid    : peer job word + one-cycle valid
//   fpu_a/fpu_b/fpu_start   : operands and issue pulse to the FP unit
//   fpu_done/fpu_result     : FP unit result and its valid
//   fpu_ovf/fpu_unf         : FP exception flags, qualified by fpu_done
//   tx_data/tx_wr_out       : {63'b0, source, R1, R0} + write strobe
//   overflow/underflow      : sticky exception status
//   clear_flags             : synchronous clear of the sticky status
//   drop_err                : pulse when an arriving job finds its slot full
//   busy                    : FSM not idle
// ---------------------------------------------------------------------------
module compute_scheduler
  import compute_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] rx_data,
  input  logic         rx_irq,
  input  logic [127:0] peer_data,
  input  logic         peer_valid,
  output logic [31:0]  fpu_a,
  output logic [31:0]  fpu_b,
  output logic         fpu_start,
  input  logic         fpu_done,
  input  logic [31:0]  fpu_result,
  input  logic         fpu_ovf,
  input  logic         fpu_unf,
  output logic [127:0] tx_data,
  output logic         tx_wr_out,
  output logic         overflow,
  output logic         underflow,
  input  logic         clear_flags,
  output logic         drop_err,
`ifdef SCHED_TIMEOUT_EN
  output logic         timeout,
`endif
  output logic         busy
);

  sched_state_e r_state;
  slot_t        r_slot_loc;
  slot_t        r_slot_peer;
  logic [31:0]  r_op1_a;
  logic [31:0]  r_op1_b;
  logic [31:0]  r_res0;
  logic         r_src;

  logic [1:0]   w_req;
  logic [1:0]   w_grant;
  logic         w_take;
  logic         w_take_loc;
  logic         w_take_peer;
  logic [127:0] w_gnt_data;
  logic         w_in_wait;
  logic         w_fpu_ack;
  logic         w_op_done;
  logic [31:0]  w_op_result;
  logic [127:0] w_tx_word;

  assign w_req       = {r_slot_peer.valid, r_slot_loc.valid};
  assign w_take      = (r_state == ST_IDLE) && (|w_req);
  assign w_take_loc  = w_take && w_grant[0];
  assign w_take_peer = w_take && w_grant[1];
  assign w_gnt_data  = w_grant[1] ? r_slot_peer.data : r_slot_loc.data;
  assign w_in_wait   = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
  // A done is only meaningful while an operation is outstanding.
  assign w_fpu_ack   = w_in_wait && fpu_done;
  assign busy        = (r_state != ST_IDLE);

  sched_rr_arbiter u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (w_req),
    .advance (w_take),
    .grant   (w_grant)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] r_to_cnt;
  logic            w_expire;

  // Expire on the TIMEOUT_CYCLES-th consecutive wait cycle without a done.
  assign w_expire    = w_in_wait && !fpu_done && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_op_done   = w_in_wait && (fpu_done || w_expire);
  assign w_op_result = fpu_done ? fpu_result : QNAN;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      // ISSUE always precedes WAIT, so the count starts from zero each time.
      r_to_cnt <= w_in_wait ? r_to_cnt + 1'b1 : '0;
      if (clear_flags) begin
        timeout <= 1'b0;
      end else if (w_expire) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign w_op_done   = w_fpu_ack;
  assign w_op_result = fpu_result;
`endif

  always_comb begin
    w_tx_word                = '0;
    w_tx_word[31:0]          = r_res0;
    w_tx_word[63:32]         = w_op_result;
    w_tx_word[TX_SRC_BIT]    = r_src;
  end

  // Holding slots. A slot being granted on this edge is free to take a new
  // word on the same edge, so a back-to-back valid is not dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot_loc  <= '0;
      r_slot_peer <= '0;
      drop_err    <= 1'b0;
    end else begin
      if (rx_irq && (!r_slot_loc.valid || w_take_loc)) begin
        r_slot_loc <= '{valid: 1'b1, data: rx_data};
      end else if (w_take_loc) begin
        r_slot_loc.valid <= 1'b0;
      end

      if (peer_valid && (!r_slot_peer.valid || w_take_peer)) begin
        r_slot_peer <= '{valid: 1'b1, data: peer_data};
      end else if (w_take_peer) begin
        r_slot_peer.valid <= 1'b0;
      end

      drop_err <= (rx_irq && r_slot_loc.valid && !w_take_loc) ||
                  (peer_valid && r_slot_peer.valid && !w_take_peer);
    end
  end

  // Job sequencer; every output is registered and set on the edge that
  // enters the state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op1_a   <= '0;
      r_op1_b   <= '0;
      r_res0    <= '0;
      r_src     <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_start <= 1'b0;
      tx_data   <= '0;
      tx_wr_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      tx_wr_out <= 1'b0;

      // Clear has priority over flags arriving on the same edge.
      if (clear_flags) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (w_fpu_ack) begin
        overflow  <= overflow | fpu_ovf;
        underflow <= underflow | fpu_unf;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            fpu_a     <= job_field(w_gnt_data, JOB_A0_LSB);
            fpu_b     <= job_field(w_gnt_data, JOB_B0_LSB);
            r_op1_a   <= job_field(w_gnt_data, JOB_A1_LSB);
            r_op1_b   <= job_field(w_gnt_data, JOB_B1_LSB);
            r_src     <= w_grant[1];
            fpu_start <= 1'b1;
            r_state   <= ST_ISSUE0;
          end
        end
        ST_ISSUE0: r_state <= ST_WAIT0;
        ST_WAIT0: begin
          if (w_op_done) begin
            r_res0    <= w_op_result;
            fpu_a     <= r_op1_a;
            fpu_b     <= r_op1_b;
            fpu_start <= 1'b1;
            r_state   <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: r_state <= ST_WAIT1;
        ST_WAIT1: begin
          if (w_op_done) begin
            tx_data   <= w_tx_word;
            tx_wr_out <= 1'b1;
            r_state   <= ST_EMIT;
          end
        end
        ST_EMIT: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
